// File: rtl/aemb_xslu_pkg.sv
// Shared definitions for the AEMB extended shift/multiply unit:
// opcodes, FSM encoding and the width helper.
package aemb_xslu_pkg;

    localparam logic [2:0] XSL_MUL   = 3'd0;
    localparam logic [2:0] XSL_MULH  = 3'd1;
    localparam logic [2:0] XSL_MULHU = 3'd2;
    localparam logic [2:0] XSL_BSLL  = 3'd3;
    localparam logic [2:0] XSL_BSRL  = 3'd4;
    localparam logic [2:0] XSL_BSRA  = 3'd5;
    localparam logic [2:0] XSL_SRC   = 3'd6;
    localparam logic [2:0] XSL_RSV   = 3'd7;

    typedef enum logic [1:0] {IDLE, SHF, MUL, FIN} xsl_state_e;

    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/aemb_xslu_if.sv
// Start/busy/ack handshake, operands, result and carry shadow of the
// extended shift/multiply unit.
interface aemb_xslu_if #(parameter int DSIZ = 32) ();

    logic            xsl_stb_i;
    logic [2:0]      xsl_op_i;
    logic [DSIZ-1:0] xsl_a_i;
    logic [DSIZ-1:0] xsl_b_i;
    logic            xsl_busy_o;
    logic            xsl_ack_o;
    logic [DSIZ-1:0] xsl_res_o;
    logic            xsl_c_o;
    logic            xsl_c_i;
    logic            xsl_cld_i;

    modport master (
        output xsl_stb_i, xsl_op_i, xsl_a_i, xsl_b_i, xsl_c_i, xsl_cld_i,
        input  xsl_busy_o, xsl_ack_o, xsl_res_o, xsl_c_o
    );

    modport slave (
        input  xsl_stb_i, xsl_op_i, xsl_a_i, xsl_b_i, xsl_c_i, xsl_cld_i,
        output xsl_busy_o, xsl_ack_o, xsl_res_o, xsl_c_o
    );

endinterface

// File: rtl/aemb_xslu_bsft.sv
// Combinational log2(DSIZ)-stage barrel shifter: logical left, logical
// right, or arithmetic right selected by mode.
module aemb_xslu_bsft
    import aemb_xslu_pkg::*;
#(
    parameter int DSIZ = 32,
    localparam int AW  = CLOG2(DSIZ)
) (
    input  logic [DSIZ-1:0] value,
    input  logic [AW-1:0]   amt,
    input  logic [2:0]      mode,
    output logic [DSIZ-1:0] result
);

    logic              left;
    logic              fill;
    logic [DSIZ-1:0]   v;
    logic [2*DSIZ-1:0] wide;

    always_comb begin
        left = (mode == XSL_BSLL);
        fill = (mode == XSL_BSRA) & value[DSIZ-1];
        v    = value;
        wide = '0;
        // Stage s moves by 2**s when amt[s] is set; right shifts pull in fill.
        for (int s = 0; s < AW; s++) begin
            if (amt[s]) begin
                if (left) begin
                    v = v << (1 << s);
                end else begin
                    wide = {{DSIZ{fill}}, v} >> (1 << s);
                    v    = wide[DSIZ-1:0];
                end
            end
        end
        result = v;
    end

endmodule

// File: rtl/aemb_xslu.sv
// AEMB extended shift/multiply unit: one-cycle barrel shifts and SRC,
// iterative MBITS-per-cycle multiply, own carry register. Falling-edge state.
module aemb_xslu
    import aemb_xslu_pkg::*;
#(
    parameter int DSIZ  = 32,
    parameter int MBITS = 4
) (
    input  logic     nclk,
    input  logic     nrst,
    input  logic     drun,
    aemb_xslu_if.slave xsl
);

    localparam int AW    = CLOG2(DSIZ);
    localparam int NITER = DSIZ / MBITS;
    localparam int CW    = CLOG2(NITER) + 1;

    xsl_state_e        state, state_n;
    logic [CW-1:0]     cnt;
    logic              busy, ack, c;
    logic [DSIZ-1:0]   res;

    logic [2:0]        op_q;
    logic [DSIZ-1:0]   a_q;
    logic [AW-1:0]     amt_q;
    logic [2*DSIZ-1:0] mcand, acc, prod;
    logic [DSIZ-1:0]   mplier;
    logic              neg_q;

    logic              start, mul_op;
    logic [DSIZ-1:0]   bsft_res, shf_res, fin_res;

    function automatic logic [DSIZ-1:0] mag(input logic signed [DSIZ-1:0] v, input logic sgn);
        return (sgn && v < 0) ? -v : v;
    endfunction

    function automatic logic [2*DSIZ-1:0] pp_sum(input logic [2*DSIZ-1:0] m,
                                                  input logic [MBITS-1:0]  d);
        logic [2*DSIZ-1:0] p;
        p = '0;
        for (int i = 0; i < MBITS; i++)
            if (d[i]) p = p + (m << i);
        return p;
    endfunction

    always_comb begin
        mul_op  = (xsl.xsl_op_i < XSL_BSLL);
        start   = (state == IDLE) && xsl.xsl_stb_i;
        state_n = state;
        case (state)
            IDLE:    if (xsl.xsl_stb_i) state_n = mul_op ? MUL : SHF;
            SHF:     state_n = IDLE;
            MUL:     if (cnt == '0) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    aemb_xslu_bsft #(.DSIZ(DSIZ)) u_bsft (
        .value  (a_q),
        .amt    (amt_q),
        .mode   (op_q),
        .result (bsft_res)
    );

    always_comb begin
        case (op_q)
            XSL_SRC: shf_res = {c, a_q[DSIZ-1:1]};
            XSL_RSV: shf_res = '0;
            default: shf_res = bsft_res;
        endcase
        prod    = neg_q ? -acc : acc;
        fin_res = (op_q == XSL_MUL) ? prod[DSIZ-1:0] : prod[2*DSIZ-1:DSIZ];
    end

    // Control stage: FSM, counter, handshake, result and carry.
    always_ff @(negedge nclk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            res   <= '0;
            c     <= 1'b0;
        end else if (drun) begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            ack   <= (state == SHF) || (state == FIN);
            if (start && mul_op)
                cnt <= CW'(NITER);
            else if (state == MUL && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == SHF)
                res <= shf_res;
            else if (state == FIN)
                res <= fin_res;
            // SRC takes priority over an MSR write landing on the same edge.
            if (state == SHF && op_q == XSL_SRC)
                c <= a_q[0];
            else if (xsl.xsl_cld_i)
                c <= xsl.xsl_c_i;
        end
    end

    // Datapath stage: operand capture and shift-add iterations on magnitudes.
    always_ff @(negedge nclk) begin
        if (drun) begin
            if (start) begin
                op_q   <= xsl.xsl_op_i;
                a_q    <= xsl.xsl_a_i;
                amt_q  <= xsl.xsl_b_i[AW-1:0];
                mcand  <= {{DSIZ{1'b0}}, mag(xsl.xsl_a_i, xsl.xsl_op_i == XSL_MULH)};
                mplier <= mag(xsl.xsl_b_i, xsl.xsl_op_i == XSL_MULH);
                acc    <= '0;
                neg_q  <= (xsl.xsl_op_i == XSL_MULH) &&
                          (xsl.xsl_a_i[DSIZ-1] ^ xsl.xsl_b_i[DSIZ-1]);
            end else if (state == MUL && cnt != '0) begin
                acc    <= acc + pp_sum(mcand, mplier[MBITS-1:0]);
                mcand  <= mcand << MBITS;
                mplier <= mplier >> MBITS;
            end
        end
    end

    assign xsl.xsl_busy_o = busy;
    assign xsl.xsl_ack_o  = ack;
    assign xsl.xsl_res_o  = res;
    assign xsl.xsl_c_o    = c;

endmodule

// File: tb/tb_aemb_xslu.sv
// Directed bench for aemb_xslu: vector table of single operations plus
// hand sequences for handshake, carry priority, freeze and reset abort.
module tb_aemb_xslu;
    import aemb_xslu_pkg::*;

    logic nclk = 1'b1;
    logic nrst;
    logic drun;
    int   n_chk  = 0;
    int   n_fail = 0;

    aemb_xslu_if #(.DSIZ(32)) xif ();

    aemb_xslu #(.DSIZ(32), .MBITS(4)) dut (
        .nclk (nclk),
        .nrst (nrst),
        .drun (drun),
        .xsl  (xif.slave)
    );

    always #5 nclk = ~nclk;

    typedef struct {
        logic        ld;
        logic        cv;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        logic        c;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input int el);
        int lat = 0;
        @(posedge nclk);
        xif.xsl_stb_i = 1'b1;
        xif.xsl_op_i  = op;
        xif.xsl_a_i   = a;
        xif.xsl_b_i   = b;
        @(posedge nclk);
        xif.xsl_stb_i = 1'b0;
        chk({nm, " busy"}, 64'(xif.xsl_busy_o), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge nclk);
            if (xif.xsl_ack_o) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 64'(lat), 64'(el));
        chk({nm, " res"}, 64'(xif.xsl_res_o), 64'(er));
        chk({nm, " busy_done"}, 64'(xif.xsl_busy_o), 64'd0);
        @(posedge nclk);
        chk({nm, " ack_width"}, 64'(xif.xsl_ack_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int extra;
        string nm;

        tbl[0]  = '{1'b0, 1'b0, XSL_BSLL,  32'h0000_00F1, 32'd4,        32'h0000_0F10, 1,  1'b0};
        tbl[1]  = '{1'b0, 1'b0, XSL_BSRA,  32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 1,  1'b0};
        tbl[2]  = '{1'b0, 1'b0, XSL_BSRL,  32'h8000_0000, 32'd31,       32'h0000_0001, 1,  1'b0};
        tbl[3]  = '{1'b1, 1'b1, XSL_SRC,   32'h0000_0003, 32'd0,        32'h8000_0001, 1,  1'b1};
        tbl[4]  = '{1'b0, 1'b0, XSL_SRC,   32'h0000_0002, 32'd0,        32'h8000_0001, 1,  1'b0};
        tbl[5]  = '{1'b0, 1'b0, XSL_MULH,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 10, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, XSL_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 10, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, XSL_MUL,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 10, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, XSL_BSLL,  32'h1234_5678, 32'd0,        32'h1234_5678, 1,  1'b0};
        tbl[9]  = '{1'b0, 1'b0, XSL_BSRL,  32'h1234_5678, 32'h24,       32'h0123_4567, 1,  1'b0};
        tbl[10] = '{1'b0, 1'b0, XSL_MULH,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 10, 1'b0};
        tbl[11] = '{1'b0, 1'b0, XSL_MUL,   32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFEB, 10, 1'b0};
        tbl[12] = '{1'b0, 1'b0, XSL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, 1'b0};
        tbl[13] = '{1'b0, 1'b0, XSL_MULH,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 10, 1'b0};
        tbl[14] = '{1'b0, 1'b0, XSL_BSRA,  32'h7000_0000, 32'd4,        32'h0700_0000, 1,  1'b0};
        tbl[15] = '{1'b0, 1'b0, XSL_MULH,  32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 10, 1'b0};
        tbl[16] = '{1'b1, 1'b1, XSL_MUL,   32'd2,         32'd3,        32'h0000_0006, 10, 1'b1};
        tbl[17] = '{1'b0, 1'b0, XSL_RSV,   32'h0000_FFFF, 32'd1,        32'h0000_0000, 1,  1'b1};
        tbl[18] = '{1'b0, 1'b0, XSL_SRC,   32'h0000_0001, 32'd0,        32'h8000_0000, 1,  1'b1};

        nrst          = 1'b0;
        drun          = 1'b1;
        xif.xsl_stb_i = 1'b0;
        xif.xsl_op_i  = 3'd0;
        xif.xsl_a_i   = '0;
        xif.xsl_b_i   = '0;
        xif.xsl_c_i   = 1'b0;
        xif.xsl_cld_i = 1'b0;
        repeat (2) @(posedge nclk);
        nrst = 1'b1;
        @(posedge nclk);
        chk("reset busy", 64'(xif.xsl_busy_o), 64'd0);
        chk("reset ack",  64'(xif.xsl_ack_o),  64'd0);
        chk("reset res",  64'(xif.xsl_res_o),  64'd0);
        chk("reset c",    64'(xif.xsl_c_o),    64'd0);

        for (int i = 0; i < 19; i++) begin
            nm = $sformatf("vec%0d", i);
            if (tbl[i].ld) begin
                @(posedge nclk);
                xif.xsl_cld_i = 1'b1;
                xif.xsl_c_i   = tbl[i].cv;
                @(posedge nclk);
                xif.xsl_cld_i = 1'b0;
            end
            run_op(nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);
            chk({nm, " c"}, 64'(xif.xsl_c_o), 64'(tbl[i].c));
        end

        // Strobe held high across the ack edge must not start a second op.
        @(posedge nclk);
        xif.xsl_stb_i = 1'b1;
        xif.xsl_op_i  = XSL_BSLL;
        xif.xsl_a_i   = 32'h1;
        xif.xsl_b_i   = 32'd8;
        @(posedge nclk);
        @(posedge nclk);
        chk("stb_at_ack ack", 64'(xif.xsl_ack_o), 64'd1);
        chk("stb_at_ack res", 64'(xif.xsl_res_o), 64'h100);
        xif.xsl_stb_i = 1'b0;
        @(posedge nclk);
        chk("stb_at_ack busy", 64'(xif.xsl_busy_o), 64'd0);

        // SRC and an MSR carry write on the same edge: SRC wins.
        @(posedge nclk);
        xif.xsl_stb_i = 1'b1;
        xif.xsl_op_i  = XSL_SRC;
        xif.xsl_a_i   = 32'h0;
        xif.xsl_b_i   = 32'h0;
        @(posedge nclk);
        xif.xsl_stb_i = 1'b0;
        xif.xsl_cld_i = 1'b1;
        xif.xsl_c_i   = 1'b1;
        @(posedge nclk);
        xif.xsl_cld_i = 1'b0;
        chk("src_vs_cld ack", 64'(xif.xsl_ack_o), 64'd1);
        chk("src_vs_cld res", 64'(xif.xsl_res_o), 64'h8000_0000);
        chk("src_vs_cld c",   64'(xif.xsl_c_o),   64'd0);

        // Carry load is ignored while drun is low.
        @(posedge nclk);
        drun          = 1'b0;
        xif.xsl_cld_i = 1'b1;
        xif.xsl_c_i   = 1'b1;
        @(posedge nclk);
        drun          = 1'b1;
        xif.xsl_cld_i = 1'b0;
        @(posedge nclk);
        chk("cld_frozen c", 64'(xif.xsl_c_o), 64'd0);

        // Multiply with a 3-cycle freeze and a stray strobe while busy.
        @(posedge nclk);
        xif.xsl_stb_i = 1'b1;
        xif.xsl_op_i  = XSL_MUL;
        xif.xsl_a_i   = 32'h0001_0001;
        xif.xsl_b_i   = 32'h0001_0001;
        @(posedge nclk);
        xif.xsl_stb_i = 1'b0;
        chk("freeze busy", 64'(xif.xsl_busy_o), 64'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge nclk);
            if (xif.xsl_ack_o) begin
                lat = k;
                break;
            end
            if (k == 5) chk("freeze res_hold", 64'(xif.xsl_res_o), 64'h8000_0000);
            if (k == 1) begin
                xif.xsl_stb_i = 1'b1;
                xif.xsl_op_i  = XSL_BSLL;
                xif.xsl_a_i   = 32'h0000_FFFF;
            end else begin
                xif.xsl_stb_i = 1'b0;
            end
            if (k == 3) drun = 1'b0;
            if (k == 6) drun = 1'b1;
        end
        chk("freeze latency", 64'(lat), 64'd13);
        chk("freeze res", 64'(xif.xsl_res_o), 64'h0002_0001);
        extra = 0;
        repeat (4) begin
            @(posedge nclk);
            if (xif.xsl_ack_o || xif.xsl_busy_o) extra++;
        end
        chk("freeze no_queued_stb", 64'(extra), 64'd0);

        // Reset in the middle of a multiply aborts it without an ack.
        @(posedge nclk);
        xif.xsl_stb_i = 1'b1;
        xif.xsl_op_i  = XSL_MUL;
        xif.xsl_a_i   = 32'd3;
        xif.xsl_b_i   = 32'd5;
        @(posedge nclk);
        xif.xsl_stb_i = 1'b0;
        repeat (4) @(posedge nclk);
        @(negedge nclk);
        nrst = 1'b0;
        #1;
        chk("abort busy", 64'(xif.xsl_busy_o), 64'd0);
        chk("abort res",  64'(xif.xsl_res_o),  64'd0);
        chk("abort ack",  64'(xif.xsl_ack_o),  64'd0);
        extra = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge nclk);
            if (k == 3) nrst = 1'b1;
            if (xif.xsl_ack_o) extra++;
        end
        chk("abort no_ack", 64'(extra), 64'd0);
        chk("abort idle", 64'(xif.xsl_busy_o), 64'd0);
        run_op("post_abort", XSL_BSLL, 32'h0000_00F1, 32'd4, 32'h0000_0F10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aemb_xslu.md
# aemb_xslu

Parametrised extended shift/multiply unit for the AEMB execute stage. It sits beside the single-cycle arithmetic/shift/logic unit and takes the operations that unit lacks:
- multi-bit barrel shifts in one cycle;
- iterative multiply, low word and signed/unsigned high word, over several cycles;
- shift-through-carry, with its own carry register.

It has a start/busy/ack handshake, so the pipeline control stalls on `xsl_busy_o`.

## Interface
Parameters:
- `DSIZ`, 32: datapath width. Power of two, 8..64.
- `MBITS`, 4: multiplier bits retired per cycle. Must be 1, 2, 4 or 8, and must divide `DSIZ`.

Ports:
- `nclk`, in, 1: clock. All state updates on the falling edge, as in the rest of the core.
- `nrst`, in, 1: asynchronous, active-low reset.
- `drun`, in, 1: pipeline run enable. When low, all state (FSM, counter, accumulators, outputs) holds.
- `xsl_stb_i`, in, 1: operation start. Sampled only when idle and `drun` = 1.
- `xsl_op_i`, in, 3: operation code; see Operation.
- `xsl_a_i`, in, `DSIZ`: operand A. For shifts this is the shifted value.
- `xsl_b_i`, in, `DSIZ`: operand B. For shifts, the amount is `b[log2(DSIZ)-1:0]`.
- `xsl_busy_o`, out, 1: operation in flight.
- `xsl_ack_o`, out, 1: one-cycle pulse; `xsl_res_o` is valid.
- `xsl_res_o`, out, `DSIZ`: result, held until the next ack.
- `xsl_c_o`, out, 1: carry register, MSR[C] shadow.
- `xsl_c_i`, in, 1: carry load value, used with `xsl_cld_i`.
- `xsl_cld_i`, in, 1: load the carry register from `xsl_c_i` (MSR write). Honoured only when `drun` = 1.

## Operation
Opcodes:
- 000 `MUL`: low `DSIZ` bits of A*B.
- 001 `MULH`: high `DSIZ` bits, signed x signed.
- 010 `MULHU`: high `DSIZ` bits, unsigned x unsigned.
- 011 `BSLL`: A << amt.
- 100 `BSRL`: A >> amt, logical.
- 101 `BSRA`: A >>> amt, arithmetic.
- 110 `SRC`: result is {C, A[DSIZ-1:1]}; new C is A[0].
- 111 reserved: completes as a shift-class op with result 0; C unchanged.

Carry rules:
- The carry register changes only on `SRC` or `xsl_cld_i`.
- If both occur in the same cycle, `SRC` wins.
- Multiply ops and barrel shifts never touch C.

FSM states:
- `IDLE`: on `stb` && `drun` go to `SHF` (op 011..111) or `MUL` (op 000..010); assert busy.
- `SHF`: compute the result in one cycle; go to `IDLE`, pulse ack.
- `MUL`: shift-add `MBITS` bits of the B magnitude per cycle into a 2*`DSIZ` accumulator. The 4-bit counter runs `DSIZ`/`MBITS` iterations; after the last iteration go to `FIN`.
- `FIN`: apply sign correction (negate if signs differ, `MULH` only); select the low or high half; go to `IDLE`, pulse ack.

Multiply arithmetic:
- Signed high uses magnitudes of A and B captured at start, with two's-complement negation of the full 2*`DSIZ` product in `FIN`.
- The most negative operand is handled exactly, since its magnitude fits in `DSIZ` unsigned bits.

Handshake and boundaries:
- Operands and opcode are latched at the start edge; inputs may change afterwards.
- `stb` while busy is ignored; it is neither queued nor an error.
- `stb` in the same cycle as ack (busy still high) is ignored. The next start is accepted one cycle after ack.
- Shift amount 0 returns A unchanged. The amount is always taken modulo `DSIZ`.
- `drun` low mid-operation freezes the counter. Latency in active cycles is unchanged, and an ack due during a freeze is held off until `drun` returns high.
- `nrst` mid-operation aborts it: FSM to `IDLE`, no ack.

## Timing
- Reset values: busy 0, ack 0, res 0, c_o 0, FSM `IDLE`, counter 0.
- Take the start edge as T0. Busy is high from T0.
- Shift-class ops: ack and result at T1; busy drops at T1.
- Multiply ops: ack at T(`DSIZ`/`MBITS` + 2), which is T10 for the defaults.
- Ack is exactly one cycle wide.
- `xsl_res_o` changes only at an ack edge or at reset.
- The new carry from `SRC` is visible on `xsl_c_o` at the ack edge.

## Structure
Shared package/include `aemb_xslu_pkg`:
- opcode constants `XSL_MUL` .. `XSL_RSV`;
- FSM state encoding (`IDLE`, `SHF`, `MUL`, `FIN`);
- the `CLOG2` function for the amount width.

Sub-module `aemb_xslu_bsft`: purely combinational barrel shifter, log2(`DSIZ`) mux stages, with ports value, amt, mode (`BSLL`/`BSRL`/`BSRA`) and result.

The FSM, multiplier datapath and carry register stay in the top level.

## Test plan
- Reset, then `BSLL` A=0x0000_00F1, B=4: ack at T1, res 0x0000_0F10, c_o stays 0.
- `BSRA` A=0x8000_0000, B=31: res 0xFFFF_FFFF. Then `BSRL` with the same operands: res 0x0000_0001.
- `xsl_cld_i`=1 with c_i=1, then `SRC` A=0x0000_0003: res 0x8000_0001, c_o=1. Then `SRC` A=0x2: res 0x8000_0001, c_o=0.
- `MULH` A=0x8000_0000, B=0xFFFF_FFFF: ack at T10, res 0x0000_0000. `MULHU` with the same operands: res 0x7FFF_FFFF. `MUL`: low word 0x8000_0000.
- `MUL` 0x0001_0001 x 0x0001_0001 with `drun` low for 3 cycles mid-op and `stb` pulsed while busy: ack at T13, res 0x0002_0001, extra `stb` ignored.
- `nrst` asserted at T5 of a `MUL`: busy 0 and res 0 immediately, no ack. Next `BSLL` completes normally at T1.
